sync_fifo_fwft: RTL and testbench
=================================

Name: sync_fifo_fwft

Overview:
- Single-clock, parameterised, first-word-fall-through FIFO with valid/ready handshakes on both sides.
- General-purpose buffering stage placed between streaming blocks in the FPGA designs.
- Pointer and count widths derive from the package ceiling-log2 function, so DEPTH need not be a power of two.

Parameters:
- DATA_WIDTH, 32, payload width in bits (>=1)
- DEPTH, 16, number of entries (>=2, any integer)
- AFULL_LEVEL, DEPTH-2, almost_full asserts when count >= AFULL_LEVEL (1..DEPTH)
- PTR_W, clog2(DEPTH), derived; read/write pointer width, not overridable
- CNT_W, clog2(DEPTH+1), derived; occupancy width, not overridable

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  DATA_WIDTH  write payload
- in_valid  in  1  write request
- in_ready  out  1  FIFO can accept a word
- out_data  out  DATA_WIDTH  head-of-queue word
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  consumer accepts the head word
- count  out  CNT_W  current occupancy, 0..DEPTH
- almost_full  out  1  count >= AFULL_LEVEL
- overflow  out  1  sticky: in_valid seen while in_ready=0 and full

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, count=0, overflow=0.
- During reset: in_ready=0, out_valid=0, almost_full=0. The storage array is not reset.
- in_ready = !rst && (count != DEPTH); out_valid = (count != 0). Both are decoded from registered count only, with no combinational path from in_valid or out_ready.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- On push: mem[wr_ptr] <= in_data; wr_ptr advances.
- On pop: rd_ptr advances.
- Pointer advance: ptr == DEPTH-1 wraps to 0, otherwise ptr+1. Do not rely on natural binary wrap; DEPTH is non-power-of-two capable.
- count: push only +1, pop only -1, both or neither unchanged. count never exceeds DEPTH and never underflows.
- out_data = mem[rd_ptr], combinational read of registered storage. The value is unspecified when out_valid=0.
- Latency: a word pushed in cycle N is visible with out_valid=1 in cycle N+1. There is no same-cycle bypass.
- Empty and push: count 0->1, out_valid rises next cycle, and out_data = pushed word.
- Full: in_ready=0, so no push occurs even if a pop occurs the same cycle. in_ready rises the cycle after the pop.
- Push+pop while partially filled: both pointers advance, count unchanged, and data order is preserved.
- out_data/out_valid remain stable while out_valid=1 and out_ready=0. Only a pop changes the head.
- overflow: set when in_valid=1 and count==DEPTH on a clock edge. Cleared only by rst.
- almost_full: registered-equivalent decode of count; updates the same cycle count changes.
- Reset mid-operation: all queued words are discarded immediately (out_valid drops asynchronously). The first word after release is the first word pushed after release.
- Data ordering is strict FIFO. No word is lost or duplicated unless overflow is set.

Test Plan:
- Reset then idle, DEPTH=16 → in_ready=1, out_valid=0, count=0, almost_full=0, overflow=0.
- Single word → push 0xA5A5_0001 in cycle 0 → out_valid=1 in cycle 1 with out_data=0xA5A5_0001; pop in cycle 1 → count=0 and out_valid=0 in cycle 2.
- Fill, DEPTH=5, AFULL_LEVEL=4 → push 1..5 with out_ready=0 → almost_full rises at count=4; at count=5 in_ready=0; extra push of 6 → overflow=1 and count stays 5; drain → reads 1,2,3,4,5.
- Wrap, DEPTH=5 → 13 cycles of continuous push+pop with values 0..12 after one priming push → count constant at 1, output sequence exactly 0..12, pointers wrap 4→0 with no loss.
- Full with simultaneous pop, DEPTH=5 → pop with in_valid=1 → that cycle no push, count=4; next cycle push accepted, count=5.
- Async reset mid-stream → assert rst between clock edges with count=3 → out_valid=0 and count=0 immediately; after release, push 0x77 → first output is 0x77.

Source files
------------

// File: rtl/sync_fifo_fwft_if.sv
// ----------------------------------------------------------------------------
// sync_fifo_fwft_if : write/read handshake and status bundle for sync_fifo_fwft
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface sync_fifo_fwft_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CNT_W-1:0]      count;
  logic                  almost_full;
  logic                  overflow;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count, almost_full, overflow
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count, almost_full, overflow
  );
endinterface

`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
// ----------------------------------------------------------------------------
// sync_fifo_fwft : single-clock first-word-fall-through FIFO, valid/ready both sides
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_fifo_fwft #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = DEPTH - 2
) (
  input  logic            clk,
  input  logic            rst,
  sync_fifo_fwft_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LEVEL);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  in_ready;
  logic                  out_valid;
  logic                  push;
  logic                  pop;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_comb begin
    in_ready   = !rst && (count_q != FULL_CNT);
    out_valid  = (count_q != '0);
    push       = bus.in_valid && in_ready;
    pop        = out_valid && bus.out_ready;
    wr_ptr_d   = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q || (bus.in_valid && (count_q == FULL_CNT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = mem_q[rd_ptr_q];
  assign bus.count       = count_q;
  assign bus.almost_full = (count_q >= AFULL_CNT);
  assign bus.overflow    = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_fwft.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_fwft : directed bench for sync_fifo_fwft at DEPTH=16 and DEPTH=5
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sync_fifo_fwft;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sync_fifo_fwft_if #(.DATA_WIDTH(32), .DEPTH(16)) bus16 ();
  sync_fifo_fwft_if #(.DATA_WIDTH(32), .DEPTH(5))  bus5  ();

  sync_fifo_fwft #(.DATA_WIDTH(32), .DEPTH(16), .AFULL_LEVEL(14)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  sync_fifo_fwft #(.DATA_WIDTH(32), .DEPTH(5), .AFULL_LEVEL(4)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        ov;
    logic [31:0] od;
    int          cnt;
    logic        ir;
    logic        af;
    logic        ovf;
  } vec_t;

  vec_t tbl [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus16.in_valid  = 1'b0;
    bus16.in_data   = '0;
    bus16.out_ready = 1'b0;
    bus5.in_valid   = 1'b0;
    bus5.in_data    = '0;
    bus5.out_ready  = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic drive5(input logic iv, input logic [31:0] id, input logic ordy);
    bus5.in_valid  = iv;
    bus5.in_data   = id;
    bus5.out_ready = ordy;
  endtask

  task automatic drive16(input logic iv, input logic [31:0] id, input logic ordy);
    bus16.in_valid  = iv;
    bus16.in_data   = id;
    bus16.out_ready = ordy;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Fill/overflow/drain table for DEPTH=5, AFULL_LEVEL=4; expectations hold after the edge.
    tbl[0]  = '{1'b1, 32'd1, 1'b0, 1'b1, 32'd1, 1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 32'd2, 1'b0, 1'b1, 32'd1, 2, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 32'd3, 1'b0, 1'b1, 32'd1, 3, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 32'd4, 1'b0, 1'b1, 32'd1, 4, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 32'd5, 1'b0, 1'b1, 32'd1, 5, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 32'd6, 1'b0, 1'b1, 32'd1, 5, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd2, 4, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd3, 3, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd4, 2, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd5, 1, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    do_reset();

    // Reset then idle, DEPTH=16
    chk("rst16_in_ready",    32'(bus16.in_ready),    32'd1);
    chk("rst16_out_valid",   32'(bus16.out_valid),   32'd0);
    chk("rst16_count",       32'(bus16.count),       32'd0);
    chk("rst16_almost_full", 32'(bus16.almost_full), 32'd0);
    chk("rst16_overflow",    32'(bus16.overflow),    32'd0);

    // Single word with one-cycle visibility latency
    drive16(1'b1, 32'hA5A5_0001, 1'b0);
    chk("single_no_bypass", 32'(bus16.out_valid), 32'd0);
    step();
    drive16(1'b0, 32'h0, 1'b1);
    chk("single_out_valid", 32'(bus16.out_valid), 32'd1);
    chk("single_out_data",  bus16.out_data,       32'hA5A5_0001);
    chk("single_count1",    32'(bus16.count),     32'd1);
    step();
    drive16(1'b0, 32'h0, 1'b0);
    chk("single_count0",    32'(bus16.count),     32'd0);
    chk("single_empty",     32'(bus16.out_valid), 32'd0);

    // Table-driven fill, overflow and drain on DEPTH=5
    for (int i = 0; i < 11; i++) begin
      drive5(tbl[i].iv, tbl[i].id, tbl[i].ordy);
      step();
      chk($sformatf("tbl%0d_out_valid", i),   32'(bus5.out_valid),   32'(tbl[i].ov));
      if (tbl[i].ov) begin
        chk($sformatf("tbl%0d_out_data", i),  bus5.out_data,         tbl[i].od);
      end
      chk($sformatf("tbl%0d_count", i),       32'(bus5.count),       32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_in_ready", i),    32'(bus5.in_ready),    32'(tbl[i].ir));
      chk($sformatf("tbl%0d_almost_full", i), 32'(bus5.almost_full), 32'(tbl[i].af));
      chk($sformatf("tbl%0d_overflow", i),    32'(bus5.overflow),    32'(tbl[i].ovf));
    end
    drive5(1'b0, 32'h0, 1'b0);

    // Continuous push+pop across several pointer wraps
    do_reset();
    chk("wrap_ovf_cleared", 32'(bus5.overflow), 32'd0);
    drive5(1'b1, 32'd0, 1'b0);
    step();
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("wrap%0d_head", i), bus5.out_data, 32'(i));
      drive5(1'b1, 32'(i + 1), 1'b1);
      step();
      chk($sformatf("wrap%0d_count", i), 32'(bus5.count), 32'd1);
    end
    drive5(1'b0, 32'h0, 1'b0);
    chk("wrap_last_head", bus5.out_data, 32'd13);

    // Full with simultaneous pop: push refused that cycle, accepted the next
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive5(1'b1, 32'(i), 1'b0);
      step();
    end
    chk("full_count5", 32'(bus5.count), 32'd5);
    drive5(1'b1, 32'h66, 1'b1);
    step();
    chk("fullpop_count4",   32'(bus5.count),    32'd4);
    chk("fullpop_in_ready", 32'(bus5.in_ready), 32'd1);
    chk("fullpop_head",     bus5.out_data,      32'd2);
    chk("fullpop_overflow", 32'(bus5.overflow), 32'd1);
    drive5(1'b1, 32'h66, 1'b0);
    step();
    chk("fullpop_refill_count", 32'(bus5.count), 32'd5);
    drive5(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("fullpop_drain%0d", i), bus5.out_data, (i == 4) ? 32'h66 : 32'(i + 2));
      step();
    end
    chk("fullpop_empty", 32'(bus5.out_valid), 32'd0);
    drive5(1'b0, 32'h0, 1'b0);

    // Stall: head stays put while out_ready is low
    drive16(1'b1, 32'h11, 1'b0);
    step();
    drive16(1'b1, 32'h22, 1'b0);
    step();
    drive16(1'b0, 32'h0, 1'b0);
    step();
    step();
    chk("stall_head",  bus16.out_data,   32'h11);
    chk("stall_count", 32'(bus16.count), 32'd2);

    // Async reset between edges discards the queue immediately
    drive16(1'b1, 32'h33, 1'b0);
    step();
    drive16(1'b0, 32'h0, 1'b0);
    chk("arst_pre_count", 32'(bus16.count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus16.out_valid),   32'd0);
    chk("arst_count",     32'(bus16.count),       32'd0);
    chk("arst_in_ready",  32'(bus16.in_ready),    32'd0);
    chk("arst_afull",     32'(bus16.almost_full), 32'd0);
    step();
    rst = 1'b0;
    step();
    drive16(1'b1, 32'h77, 1'b0);
    step();
    drive16(1'b0, 32'h0, 1'b1);
    chk("arst_first_valid", 32'(bus16.out_valid), 32'd1);
    chk("arst_first_data",  bus16.out_data,       32'h77);
    step();
    drive16(1'b0, 32'h0, 1'b0);
    chk("arst_drained", 32'(bus16.count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
